// File: rtl/cpu_alu_decode.sv
// rtl/cpu_alu_decode.sv - 8-bit ALU with registered Z/C flags and x/y/z opcode field decoder
// Optional p/q decode outputs are enabled by defining CPU_DECODE_PQ_EN.
module cpu_alu_decode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic [2:0] operator,
  output logic [7:0] result,
  output logic       flag_zero,
  output logic       flag_carry,
  input  logic [7:0] insn,
  output logic [1:0] insn_x,
  output logic [2:0] insn_y,
  output logic [2:0] insn_z
`ifdef CPU_DECODE_PQ_EN
  ,
  output logic [1:0] insn_p,
  output logic       insn_q
`endif
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_ADC = 3'd6;
  localparam logic [2:0] OP_SBC = 3'd7;

  logic [8:0] a9;
  logic [8:0] b9;
  logic [8:0] cin9;
  logic [8:0] res9;
  logic       carry_next;

  assign a9   = {1'b0, operand_a};
  assign b9   = {1'b0, operand_b};
  assign cin9 = {8'd0, flag_carry};

  // Subtraction in 9 bits leaves bit 8 set exactly when a < b + cin (borrow).
  always_comb begin
    res9       = a9;
    carry_next = 1'b0;
    case (operator)
      OP_NOP: res9 = a9;
      OP_ADD: begin res9 = a9 + b9;        carry_next = res9[8]; end
      OP_SUB: begin res9 = a9 - b9;        carry_next = res9[8]; end
      OP_AND: res9 = a9 & b9;
      OP_OR:  res9 = a9 | b9;
      OP_XOR: res9 = a9 ^ b9;
      OP_ADC: begin res9 = a9 + b9 + cin9; carry_next = res9[8]; end
      OP_SBC: begin res9 = a9 - b9 - cin9; carry_next = res9[8]; end
      default: begin res9 = a9; carry_next = 1'b0; end
    endcase
  end

  assign result = res9[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (operator != OP_NOP) begin
      flag_zero  <= (res9[7:0] == 8'd0);
      flag_carry <= carry_next;
    end
  end

  assign insn_x = insn[7:6];
  assign insn_y = insn[5:3];
  assign insn_z = insn[2:0];
`ifdef CPU_DECODE_PQ_EN
  assign insn_p = insn[5:4];
  assign insn_q = insn[3];
`endif

endmodule

// File: tb/tb_cpu_alu_decode.sv
// tb/tb_cpu_alu_decode.sv - scoreboard bench for cpu_alu_decode
// Define CPU_DECODE_PQ_EN to also exercise the p/q decode outputs.
module tb_cpu_alu_decode;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, ADC = 3'd6, SBC = 3'd7;

  logic       clk;
  logic       rst_n;
  logic [7:0] operand_a, operand_b, result, insn;
  logic [2:0] operator, insn_y, insn_z;
  logic [1:0] insn_x;
  logic       flag_zero, flag_carry;
`ifdef CPU_DECODE_PQ_EN
  logic [1:0] insn_p;
  logic       insn_q;
`endif

  cpu_alu_decode dut (
    .clk(clk), .rst_n(rst_n),
    .operand_a(operand_a), .operand_b(operand_b), .operator(operator),
    .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .insn(insn), .insn_x(insn_x), .insn_y(insn_y), .insn_z(insn_z)
`ifdef CPU_DECODE_PQ_EN
    , .insn_p(insn_p), .insn_q(insn_q)
`endif
  );

  typedef struct {
    string      name;
    bit         chk_res;
    logic [7:0] res;
    bit         chk_flags;
    logic       z;
    logic       c;
    bit         chk_dec;
    logic [1:0] x;
    logic [2:0] y;
    logic [2:0] z3;
    logic [1:0] p;
    logic       q;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, want);
    end
  endtask

  // Monitor: outputs are combinational/registered with no handshake, so the
  // bench samples everything queued so far at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (scb.size() > 0) begin
        e = scb.pop_front();
        if (e.chk_res) cmp({e.name, ".result"}, result, e.res);
        if (e.chk_flags) begin
          cmp({e.name, ".Z"}, {7'd0, flag_zero}, {7'd0, e.z});
          cmp({e.name, ".C"}, {7'd0, flag_carry}, {7'd0, e.c});
        end
        if (e.chk_dec) begin
          cmp({e.name, ".x"}, {6'd0, insn_x}, {6'd0, e.x});
          cmp({e.name, ".y"}, {5'd0, insn_y}, {5'd0, e.y});
          cmp({e.name, ".z"}, {5'd0, insn_z}, {5'd0, e.z3});
`ifdef CPU_DECODE_PQ_EN
          cmp({e.name, ".p"}, {6'd0, insn_p}, {6'd0, e.p});
          cmp({e.name, ".q"}, {7'd0, insn_q}, {7'd0, e.q});
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    operator  = op;
    operand_a = a;
    operand_b = b;
  endtask

  task automatic exp_res(input string n, input logic [7:0] r);
    exp_t e;
    e = '{default: '0};
    e.name = n; e.chk_res = 1'b1; e.res = r;
    scb.push_back(e);
  endtask

  task automatic exp_flags(input string n, input logic z, input logic c);
    exp_t e;
    e = '{default: '0};
    e.name = n; e.chk_flags = 1'b1; e.z = z; e.c = c;
    scb.push_back(e);
  endtask

  task automatic exp_dec(input string n, input logic [1:0] x, input logic [2:0] y,
                         input logic [2:0] z, input logic [1:0] p, input logic q);
    exp_t e;
    e = '{default: '0};
    e.name = n; e.chk_dec = 1'b1; e.x = x; e.y = y; e.z3 = z; e.p = p; e.q = q;
    scb.push_back(e);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    insn  = 8'h00;
    drive(ADD, 8'hFF, 8'h01);

    // Reset: flags forced low even with a flag-setting op present
    step(); exp_flags("rst", 1'b0, 1'b0); exp_res("rst_comb", 8'h00);
    step(); exp_flags("rst_hold", 1'b0, 1'b0);
    step(); rst_n = 1'b1; drive(NOP, 8'h00, 8'h00); exp_flags("rst_rel", 1'b0, 1'b0);

    // Decoder
    insn = 8'hC3; #1; exp_dec("dec_C3", 2'd3, 3'd0, 3'd3, 2'd0, 1'b0);
    step(); insn = 8'h3E; exp_dec("dec_3E", 2'd0, 3'd7, 3'd6, 2'd3, 1'b1);

    // ADD wrap
    step(); drive(ADD, 8'hFF, 8'h01); exp_res("add_wrap", 8'h00);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("add_wrap", 1'b1, 1'b1);

    // SUB borrow then NOP hold
    step(); drive(SUB, 8'h00, 8'h01); exp_res("sub_borrow", 8'hFF);
    step(); drive(NOP, 8'h12, 8'h00); exp_flags("sub_borrow", 1'b0, 1'b1); exp_res("nop_pass", 8'h12);
    step(); exp_flags("nop_hold1", 1'b0, 1'b1);
    step(); exp_flags("nop_hold2", 1'b0, 1'b1);

    // ADC chain
    step(); drive(ADD, 8'hFF, 8'h01);
    step(); drive(ADC, 8'h10, 8'h20); exp_res("adc", 8'h31); exp_flags("adc_pre", 1'b1, 1'b1);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("adc", 1'b0, 1'b0);

    // Logic ops clear carry
    step(); drive(ADD, 8'hFF, 8'h01);
    step(); drive(AND_, 8'hF0, 8'h0F); exp_res("and", 8'h00);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("and", 1'b1, 1'b0);
    step(); drive(OR_, 8'hF0, 8'h0F); exp_res("or", 8'hFF);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("or", 1'b0, 1'b0);
    step(); drive(XOR_, 8'h5A, 8'h5A); exp_res("xor", 8'h00);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("xor", 1'b1, 1'b0);

    // SBC with carry in
    step(); drive(SUB, 8'h00, 8'h01);
    step(); drive(SBC, 8'h10, 8'h05); exp_res("sbc_nb", 8'h0A);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("sbc_nb", 1'b0, 1'b0);
    step(); drive(SUB, 8'h00, 8'h01);
    step(); drive(SBC, 8'h05, 8'h05); exp_res("sbc_b", 8'hFF);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("sbc_b", 1'b0, 1'b1);

    // Async reset between edges
    step(); drive(ADD, 8'hFF, 8'h01);
    step(); drive(NOP, 8'h00, 8'h00); exp_flags("pre_rst", 1'b1, 1'b1);
    step(); rst_n = 1'b0; drive(ADD, 8'hFF, 8'h01); exp_flags("async_rst", 1'b0, 1'b0);
    step(); exp_flags("async_hold", 1'b0, 1'b0);
    step(); rst_n = 1'b1; drive(NOP, 8'h00, 8'h00); exp_flags("async_rel", 1'b0, 1'b0);

    waited = 0;
    while (scb.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (scb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
